// File: rtl/trng_pkg.sv
// Shared state encoding and default sizing for the TRNG entropy collector.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_COLLECT,
        ST_FAIL
    } state_e;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned WARMUP_BITS = 8;
    localparam int unsigned RCT_CUTOFF  = 16;
    localparam int unsigned APT_WINDOW  = 64;
    localparam int unsigned APT_CUTOFF  = 48;

endpackage

// File: rtl/trng_collector_if.sv
// Entropy-bit input, word output handshake and status flags of the collector.
interface trng_collector_if #(
    parameter int unsigned WORD_W = trng_pkg::WORD_W
);
    logic              i_valid;
    logic              i_bit;
    logic              i_ready;
    logic [WORD_W-1:0] o_data;
    logic              o_valid;
    logic              o_health_fail;
    logic              o_overrun;

    modport master (
        output i_valid, i_bit, i_ready,
        input  o_data, o_valid, o_health_fail, o_overrun
    );

    modport slave (
        input  i_valid, i_bit, i_ready,
        output o_data, o_valid, o_health_fail, o_overrun
    );
endinterface

// File: rtl/trng_health.sv
// Repetition-count and adaptive-proportion health tests; fail pulses
// combinationally on the valid bit that reaches either cutoff.
module trng_health
    import trng_pkg::*;
#(
    parameter int unsigned RCT_CUTOFF = trng_pkg::RCT_CUTOFF,
    parameter int unsigned APT_WINDOW = trng_pkg::APT_WINDOW,
    parameter int unsigned APT_CUTOFF = trng_pkg::APT_CUTOFF
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic bit_in,
    output logic fail
);
    localparam int unsigned RCT_W = $clog2(RCT_CUTOFF) + 1;
    localparam int unsigned WIN_W = $clog2(APT_WINDOW) + 1;
    localparam int unsigned APT_W = $clog2(APT_CUTOFF) + 1;

    localparam logic [RCT_W-1:0] RCT_ONE  = RCT_W'(1);
    localparam logic [RCT_W-1:0] RCT_LIM  = RCT_W'(RCT_CUTOFF);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(APT_WINDOW - 1);
    localparam logic [APT_W-1:0] APT_ONE  = APT_W'(1);
    localparam logic [APT_W-1:0] APT_LIM  = APT_W'(APT_CUTOFF);

    logic [RCT_W-1:0] run_q, run_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [APT_W-1:0] apt_q, apt_d;
    logic             last_q, last_d;
    logic             seen_q, seen_d;
    logic             ref_q, ref_d;

    always_comb begin
        run_d  = run_q;
        win_d  = win_q;
        apt_d  = apt_q;
        last_d = last_q;
        seen_d = seen_q;
        ref_d  = ref_q;
        fail   = 1'b0;
        if (valid) begin
            seen_d = 1'b1;
            last_d = bit_in;
            // Counters saturate at their cutoff so they can never wrap.
            if (!seen_q || (bit_in != last_q)) begin
                run_d = RCT_ONE;
            end else if (run_q != RCT_LIM) begin
                run_d = run_q + RCT_ONE;
            end
            if (win_q == '0) begin
                ref_d = bit_in;
                apt_d = APT_ONE;
            end else if ((bit_in == ref_q) && (apt_q != APT_LIM)) begin
                apt_d = apt_q + APT_ONE;
            end
            win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_ONE;
            fail  = (run_d == RCT_LIM) || (apt_d == APT_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            win_q  <= '0;
            apt_q  <= '0;
            last_q <= 1'b0;
            seen_q <= 1'b0;
            ref_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            win_q  <= win_d;
            apt_q  <= apt_d;
            last_q <= last_d;
            seen_q <= seen_d;
            ref_q  <= ref_d;
        end
    end
endmodule

// File: rtl/trng_collector.sv
// Discards warm-up bits, packs entropy bits LSB-first into words and
// presents them on a valid/ready handshake; a health failure locks out output.
module trng_collector
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W      = trng_pkg::WORD_W,
    parameter int unsigned WARMUP_BITS = trng_pkg::WARMUP_BITS,
    parameter int unsigned RCT_CUTOFF  = trng_pkg::RCT_CUTOFF,
    parameter int unsigned APT_WINDOW  = trng_pkg::APT_WINDOW,
    parameter int unsigned APT_CUTOFF  = trng_pkg::APT_CUTOFF
) (
    input  logic             clk,
    input  logic             rst,
    trng_collector_if.slave  bus
);
    localparam int unsigned WARM_W = $clog2(WARMUP_BITS) + 1;
    localparam int unsigned PACK_W = $clog2(WORD_W) + 1;

    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_BITS - 1);
    localparam logic [PACK_W-1:0] PACK_ONE  = PACK_W'(1);
    localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [PACK_W-1:0] pack_cnt_q, pack_cnt_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              fail_q, fail_d;
    logic              overrun_q, overrun_d;

    logic              bit_valid;
    logic              health_fail;
    logic              accept;
    logic              word_done;
    logic [WORD_W-1:0] word;

    assign bit_valid = bus.i_valid && (state_q != ST_FAIL);

    trng_health #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk    (clk),
        .rst    (rst),
        .valid  (bit_valid),
        .bit_in (bus.i_bit),
        .fail   (health_fail)
    );

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        pack_cnt_d = pack_cnt_q;
        pack_d     = pack_q;
        data_d     = data_q;
        valid_d    = valid_q;
        fail_d     = fail_q;
        overrun_d  = overrun_q;
        word_done  = 1'b0;
        accept     = valid_q && bus.i_ready;
        word       = {bus.i_bit, pack_q[WORD_W-1:1]};

        if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_WARMUP: begin
                if (bit_valid) begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = ST_COLLECT;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WARM_ONE;
                    end
                end
            end
            ST_COLLECT: begin
                if (bit_valid) begin
                    pack_d = word;
                    if (pack_cnt_q == PACK_LAST) begin
                        pack_cnt_d = '0;
                        word_done  = 1'b1;
                    end else begin
                        pack_cnt_d = pack_cnt_q + PACK_ONE;
                    end
                end
            end
            default: ;
        endcase

        // A slot is free if nothing is held or the held word leaves this cycle.
        if (word_done) begin
            if (!valid_q || accept) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Health failure overrides any word completing on the same bit.
        if (health_fail) begin
            state_d = ST_FAIL;
            valid_d = 1'b0;
            fail_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WARMUP;
            warm_cnt_q <= '0;
            pack_cnt_q <= '0;
            pack_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fail_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            pack_cnt_q <= pack_cnt_d;
            pack_q     <= pack_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fail_q     <= fail_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.o_data        = data_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_health_fail = fail_q;
    assign bus.o_overrun     = overrun_q;
endmodule

// File: tb/tb_trng_collector.sv
// Directed scenarios for trng_collector: warm-up, packing, handshake,
// overrun, health-test failures and reset recovery.
module tb_trng_collector;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [3:0] pat;

    trng_collector_if #(.WORD_W(32)) bus ();

    trng_collector #(
        .WORD_W      (32),
        .WARMUP_BITS (8),
        .RCT_CUTOFF  (16),
        .APT_WINDOW  (64),
        .APT_CUTOFF  (48)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and return just after a falling edge.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_bit   = b;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_bit   = 1'b1;
        repeat (3) @(negedge clk);
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_bit   = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_ready = 1'b0;
        do_reset();
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", bus.o_data); end
        n_cmp++; if (bus.o_health_fail !== 1'b0) begin n_bad++; $display("FAIL reset_health: got %b want 0", bus.o_health_fail); end
        n_cmp++; if (bus.o_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", bus.o_overrun); end
    endtask

    task automatic test_word();
        bus.i_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 39; k++) begin
            send_bit(logic'(k % 2), 4);
            n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL word_early_valid bit %0d: got %b want 0", k, bus.o_valid); end
        end
        send_bit(1'b0, 4);
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL word_valid: got %b want 1", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 32'h55555555) begin n_bad++; $display("FAIL word_data: got %h want 55555555", bus.o_data); end
        n_cmp++; if (bus.o_health_fail !== 1'b0) begin n_bad++; $display("FAIL word_health: got %b want 0", bus.o_health_fail); end
        @(negedge clk);
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL word_pulse: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_midword_reset();
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 20; k++) send_bit(logic'(k % 2), 0);
        do_reset();
        n_cmp++; if (bus.o_data !== 32'h0) begin n_bad++; $display("FAIL mid_reset_data: got %h want 00000000", bus.o_data); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", bus.o_valid); end
        for (int k = 1; k <= 39; k++) begin
            send_bit(logic'(k % 2), 0);
            n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_early bit %0d: got %b want 0", k, bus.o_valid); end
        end
        send_bit(1'b0, 0);
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL mid_reset_valid_after: got %b want 1", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 32'h55555555) begin n_bad++; $display("FAIL mid_reset_data_after: got %h want 55555555", bus.o_data); end
    endtask

    task automatic test_rct();
        bus.i_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 8; k++) send_bit(logic'(k % 2), 0);
        for (int k = 1; k <= 15; k++) send_bit(1'b1, 0);
        n_cmp++; if (bus.o_health_fail !== 1'b0) begin n_bad++; $display("FAIL rct_before: got %b want 0", bus.o_health_fail); end
        send_bit(1'b1, 0);
        n_cmp++; if (bus.o_health_fail !== 1'b1) begin n_bad++; $display("FAIL rct_fail: got %b want 1", bus.o_health_fail); end
        for (int k = 1; k <= 40; k++) begin
            send_bit(logic'(k % 2), 0);
            n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL rct_locked_valid bit %0d: got %b want 0", k, bus.o_valid); end
        end
        n_cmp++; if (bus.o_health_fail !== 1'b1) begin n_bad++; $display("FAIL rct_sticky: got %b want 1", bus.o_health_fail); end
    endtask

    task automatic test_apt();
        bus.i_ready = 1'b1;
        do_reset();
        n_cmp++; if (bus.o_health_fail !== 1'b0) begin n_bad++; $display("FAIL apt_reset_from_fail: got %b want 0", bus.o_health_fail); end
        for (int j = 0; j < 63; j++) begin
            send_bit(pat[j % 4], 0);
            if (j == 39) begin
                n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL apt_word_valid: got %b want 1", bus.o_valid); end
                n_cmp++; if (bus.o_data !== 32'hBBBBBBBB) begin n_bad++; $display("FAIL apt_word_data: got %h want bbbbbbbb", bus.o_data); end
            end
        end
        n_cmp++; if (bus.o_health_fail !== 1'b0) begin n_bad++; $display("FAIL apt_before: got %b want 0", bus.o_health_fail); end
        send_bit(pat[3], 0);
        n_cmp++; if (bus.o_health_fail !== 1'b1) begin n_bad++; $display("FAIL apt_fail: got %b want 1", bus.o_health_fail); end
    endtask

    task automatic test_fail_on_word();
        bus.i_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 24; k++) send_bit(logic'(k % 2), 0);
        for (int k = 25; k <= 39; k++) send_bit(1'b1, 0);
        n_cmp++; if (bus.o_health_fail !== 1'b0) begin n_bad++; $display("FAIL fow_before: got %b want 0", bus.o_health_fail); end
        send_bit(1'b1, 0);
        n_cmp++; if (bus.o_health_fail !== 1'b1) begin n_bad++; $display("FAIL fow_health: got %b want 1", bus.o_health_fail); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL fow_valid: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_overrun();
        bus.i_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 40; k++) send_bit(logic'(k % 2), 0);
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_first_valid: got %b want 1", bus.o_valid); end
        n_cmp++; if (bus.o_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_not_yet: got %b want 0", bus.o_overrun); end
        for (int k = 41; k <= 72; k++) send_bit(logic'(k % 2), 0);
        n_cmp++; if (bus.o_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", bus.o_overrun); end
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_held_valid: got %b want 1", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 32'h55555555) begin n_bad++; $display("FAIL ovr_held_data: got %h want 55555555", bus.o_data); end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_accept: got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", bus.o_overrun); end
    endtask

    task automatic test_back_to_back();
        bus.i_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 40; k++) send_bit(logic'(k % 2), 0);
        for (int j = 0; j < 31; j++) begin
            send_bit(pat[j % 4], 0);
            n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_hold_valid bit %0d: got %b want 1", j + 41, bus.o_valid); end
        end
        n_cmp++; if (bus.o_data !== 32'h55555555) begin n_bad++; $display("FAIL b2b_first_data: got %h want 55555555", bus.o_data); end
        bus.i_ready = 1'b1;
        send_bit(pat[3], 0);
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_no_bubble: got %b want 1", bus.o_valid); end
        n_cmp++; if (bus.o_data !== 32'hBBBBBBBB) begin n_bad++; $display("FAIL b2b_second_data: got %h want bbbbbbbb", bus.o_data); end
        n_cmp++; if (bus.o_overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", bus.o_overrun); end
        @(negedge clk);
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", bus.o_valid); end
        bus.i_ready = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        pat         = 4'b1011;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_bit   = 1'b0;
        bus.i_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_word();
        test_midword_reset();
        test_rct();
        test_apt();
        test_fail_on_word();
        test_overrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/trng_collector.md
TRNG_COLLECTOR -- requirements
Module: trng_collector

Interface
REQ-001 Parameter WORD_W, 32, width of packed output word.
REQ-002 Parameter WARMUP_BITS, 8, number of valid bits discarded after reset.
REQ-003 Parameter RCT_CUTOFF, 16, repetition-count limit on identical consecutive bits.
REQ-004 Parameter APT_WINDOW, 64, adaptive-proportion window length in bits.
REQ-005 Parameter APT_CUTOFF, 48, adaptive-proportion limit within one window.
REQ-006 Port clk, input, 1, single clock; all logic on posedge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port i_valid, input, 1, one-cycle strobe; i_bit is valid this cycle.
REQ-009 Port i_bit, input, 1, raw entropy bit from the TRNG warbler output.
REQ-010 Port o_data, output, WORD_W, packed random word.
REQ-011 Port o_valid, output, 1, o_data holds an unconsumed word.
REQ-012 Port i_ready, input, 1, consumer accepts o_data when o_valid and i_ready are both high.
REQ-013 Port o_health_fail, output, 1, sticky health-test failure.
REQ-014 Port o_overrun, output, 1, sticky flag: at least one completed word was discarded.

Function
REQ-015 FSM states: WARMUP, COLLECT, FAIL; every input bit is sampled only on cycles with i_valid=1.
REQ-016 WARMUP: count valid bits; after the WARMUP_BITS-th bit, enter COLLECT next cycle; warm-up bits are never packed.
REQ-017 COLLECT: shift each valid bit into the pack register LSB-first; the first packed bit is o_data[0].
REQ-018 When the WORD_W-th bit arrives, load the output register on the next cycle and set o_valid; the pack counter wraps to 0 in the same cycle.
REQ-019 o_valid stays high with o_data stable until a cycle with i_ready=1; it clears on the following cycle unless a new word loads in that same cycle.
REQ-020 Simultaneous handshake and word completion: the new word loads and o_valid remains 1 with no bubble.
REQ-021 Word completes while o_valid=1 and i_ready=0: discard the new word, keep the held word, set o_overrun; packing continues.
REQ-022 Health tests run on every valid bit from the first bit after reset, including warm-up bits.
REQ-023 RCT: count the run of identical consecutive bits, with the first bit giving a run of 1; when the run reaches RCT_CUTOFF, enter FAIL.
REQ-024 APT: the first bit of each window is the reference; count window bits equal to the reference, including the reference itself; when the count reaches APT_CUTOFF, enter FAIL; the window restarts after APT_WINDOW bits.
REQ-025 FAIL is entered on the cycle after the offending bit; o_health_fail=1, o_valid=0, the pending word is dropped, and further input is ignored until rst.
REQ-026 A failure detected on the same bit that completes a word takes priority; that word is never presented.

Reset
REQ-027 rst=1 forces: state WARMUP; o_data=0; o_valid=0; o_health_fail=0; o_overrun=0; all counters and the pack register cleared.
REQ-028 rst asserted mid-word or in FAIL discards all partial state; warm-up restarts.
REQ-029 i_valid during rst is ignored.

Structure
REQ-030 Package trng_pkg holds the state enum and default parameter constants (WORD_W, WARMUP_BITS, RCT_CUTOFF, APT_WINDOW, APT_CUTOFF).
REQ-031 The RCT and APT logic lives in sub-module trng_health (inputs: clk, rst, valid, bit; output: fail pulse); the FSM and packing stay in trng_collector.
REQ-032 Counter widths are sized with $clog2 of their limit plus 1; no counter may overflow before reaching its cutoff.

Verification
REQ-033 Reset, then 8 valid bits followed by 32 alternating bits starting with 1 (one strobe every 5 cycles), i_ready=1 -> o_valid pulses 1 cycle after the 40th bit, o_data=32'h55555555, o_health_fail=0.
REQ-034 After warm-up, 16 consecutive 1s -> o_health_fail=1 on the cycle after the 16th; o_valid stays 0 afterwards, including for later input.
REQ-035 Pattern 1,1,0,1 repeated 16 times from reset -> no RCT fail; APT count reaches 48 on bit 64 -> o_health_fail=1 the next cycle.
REQ-036 i_ready=0, 8+64 alternating bits -> first word held as 32'h55555555, o_overrun=1 after the 72nd bit; i_ready=1 -> accepted once, o_valid drops.
REQ-037 i_ready=1 asserted on the same cycle the next word completes -> o_valid stays high continuously and both words are seen.
REQ-038 rst pulsed after 20 packed bits -> all outputs 0; the next word requires a full 8+32 bits.
